// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for a 16:1 selection lane: registered select/one-hot grant
// with a per-winner hold limit, plus the arbitrated data bit.
module mux_rr_arbiter #(
  parameter int unsigned IN_LENGTH  = 16,
  parameter int unsigned SEL_LENGTH = 4,
  parameter int unsigned MAX_HOLD   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [IN_LENGTH-1:0]  req,
  input  logic [IN_LENGTH-1:0]  in,
  output logic [SEL_LENGTH-1:0] sel,
  output logic [IN_LENGTH-1:0]  grant,
  output logic                  valid,
  output logic                  last,
  output logic                  out
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e                state_q, state_d;
  logic [SEL_LENGTH-1:0] ptr_q, ptr_d;
  logic [SEL_LENGTH-1:0] sel_q, sel_d;
  logic [7:0]            hold_cnt_q, hold_cnt_d;
  logic [IN_LENGTH-1:0]  grant_q, grant_d;
  logic                  valid_q, valid_d;

  logic [SEL_LENGTH-1:0] winner;
  logic [SEL_LENGTH-1:0] idx;
  logic                  found;
  logic                  release_c;

  // Upward search from ptr; the select width wraps the index 15 -> 0.
  always_comb begin
    winner = ptr_q;
    idx    = ptr_q;
    found  = 1'b0;
    for (int unsigned i = 0; i < IN_LENGTH; i++) begin
      idx = ptr_q + SEL_LENGTH'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign release_c = !en || !req[sel_q] || (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    valid_d    = valid_q;
    case (state_q)
      IDLE: begin
        if (en && found) begin
          state_d    = GRANT;
          sel_d      = winner;
          grant_d    = IN_LENGTH'(1) << winner;
          valid_d    = 1'b1;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (release_c) begin
          state_d    = IDLE;
          valid_d    = 1'b0;
          grant_d    = '0;
          hold_cnt_d = '0;
          ptr_d      = sel_q + SEL_LENGTH'(1);
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      hold_cnt_q <= '0;
      grant_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      valid_q    <= valid_d;
    end
  end

  assign sel   = sel_q;
  assign grant = grant_q;
  assign valid = valid_q;
  assign last  = valid_q & (hold_cnt_q == HOLD_LAST);
  assign out   = valid_q & in[sel_q];

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed-vector bench for mux_rr_arbiter with hand-computed expectations.
module tb_mux_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] req;
  logic [15:0] in;
  logic [3:0]  sel;
  logic [15:0] grant;
  logic        valid;
  logic        last;
  logic        out;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(
    .IN_LENGTH (16),
    .SEL_LENGTH(4),
    .MAX_HOLD  (8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .req  (req),
    .in   (in),
    .sel  (sel),
    .grant(grant),
    .valid(valid),
    .last (last),
    .out  (out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_sel, input logic [15:0] e_grant,
                         input logic e_valid, input logic e_last, input logic e_out);
    chk({tag, ".sel"},   {12'b0, sel},   {12'b0, e_sel});
    chk({tag, ".grant"}, grant,          e_grant);
    chk({tag, ".valid"}, {15'b0, valid}, {15'b0, e_valid});
    chk({tag, ".last"},  {15'b0, last},  {15'b0, e_last});
    chk({tag, ".out"},   {15'b0, out},   {15'b0, e_out});
  endtask

  initial begin
    logic [3:0] w;

    // Reset held with all requests up
    rst = 1'b1;
    en  = 1'b1;
    req = 16'hFFFF;
    in  = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("reset", 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    end

    // Single holder on requester 5
    rst = 1'b0;
    req = 16'h0020;
    in  = 16'h0020;
    tick();
    chk_all("single.g0", 4'd5, 16'h0020, 1'b1, 1'b0, 1'b1);
    in = 16'h0000;
    #1;
    chk({"single.outcomb"}, {15'b0, out}, 16'h0000);
    in = 16'h0020;
    tick();
    chk_all("single.g1", 4'd5, 16'h0020, 1'b1, 1'b0, 1'b1);
    tick();
    chk_all("single.g2", 4'd5, 16'h0020, 1'b1, 1'b0, 1'b1);
    req = 16'h0000;
    tick();
    chk_all("single.rel", 4'd5, 16'h0000, 1'b0, 1'b0, 1'b0);
    // ptr=6: search wraps to requester 0
    req = 16'h0021;
    tick();
    chk_all("single.wrap", 4'd0, 16'h0001, 1'b1, 1'b0, 1'b0);
    req = 16'h0000;
    tick();
    chk_all("single.rel2", 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Timeout on requester 2
    req = 16'h0004;
    in  = 16'h0004;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_all("timeout.hold", 4'd2, 16'h0004, 1'b1, (k == 7), 1'b1);
    end
    tick();
    chk_all("timeout.bubble", 4'd2, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("timeout.regrant", 4'd2, 16'h0004, 1'b1, 1'b0, 1'b1);
    req = 16'h0000;
    tick();
    chk_all("timeout.rel", 4'd2, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Round-robin between 0 and 15 from ptr=0
    rst = 1'b1;
    tick();
    chk_all("rr.reset", 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    req = 16'h8001;
    in  = 16'h8001;
    for (int g = 0; g < 4; g++) begin
      w = (g % 2 == 1) ? 4'd15 : 4'd0;
      for (int k = 0; k < 8; k++) begin
        tick();
        chk_all("rr.hold", w, (g % 2 == 1) ? 16'h8000 : 16'h0001, 1'b1, (k == 7), 1'b1);
      end
      tick();
      chk_all("rr.bubble", w, 16'h0000, 1'b0, 1'b0, 1'b0);
    end
    req = 16'h0000;

    // Enable low blocks arbitration
    en  = 1'b0;
    req = 16'h00FF;
    in  = 16'h00FF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("en.off", 4'd15, 16'h0000, 1'b0, 1'b0, 1'b0);
    end
    en = 1'b1;
    tick();
    chk_all("en.g0", 4'd0, 16'h0001, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk_all("en.hold", 4'd0, 16'h0001, 1'b1, 1'b0, 1'b1);
    end
    en = 1'b0;
    tick();
    chk_all("en.drop", 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    tick();
    chk_all("en.ptradv", 4'd1, 16'h0002, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of a grant to requester 9
    req = 16'h0200;
    in  = 16'h0200;
    tick();
    chk_all("mid.rel1", 4'd1, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("mid.g9", 4'd9, 16'h0200, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_all("mid.hold", 4'd9, 16'h0200, 1'b1, 1'b0, 1'b1);
    end
    rst = 1'b1;
    tick();
    chk_all("mid.reset", 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    req = 16'h0030;
    in  = 16'h0010;
    tick();
    chk_all("mid.after", 4'd4, 16'h0010, 1'b1, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and sequencer for the 16:1 selection datapath. Shares one output lane between 16 requesters: picks one requester, drives the registered select code and a one-hot grant, and holds the grant until the requester releases or a hold limit expires. It also provides the selected data bit, so downstream logic sees one arbitrated, time-multiplexed bit stream.

## Interface
- IN_LENGTH, 16, number of requesters / data inputs (fixed at 16 for this block)
- SEL_LENGTH, 4, select code width, log2(IN_LENGTH)
- MAX_HOLD, 8, maximum consecutive grant cycles per winner; legal range 1..255

- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  arbitration enable
- req  input  IN_LENGTH  per-requester request, level-sensitive
- in  input  IN_LENGTH  data bits, in[i] belongs to requester i
- sel  output  SEL_LENGTH  registered index of current/last winner
- grant  output  IN_LENGTH  registered one-hot grant, all-zero when idle
- valid  output  1  registered, 1 while a grant is active
- last  output  1  1 during the final cycle of a grant that ends by hold-limit timeout
- out  output  1  combinational, valid & in[sel]

## Operation
- Internal state: FSM {IDLE, GRANT}, round-robin pointer ptr[3:0], hold counter hold_cnt[7:0].
- Reset (rst=1 at a clk edge) sets state=IDLE, ptr=0, hold_cnt=0, sel=0, grant=0, valid=0, last=0. Reset takes priority over every other event.
- IDLE, en=1, req!=0: the winner is the first set req bit found by searching upward from ptr, wrapping 15->0. At the edge: sel=winner, grant=1<<winner, valid=1, hold_cnt=0, state=GRANT.
- IDLE, en=0 or req=0: stays in IDLE. sel holds its last value and grant=0.
- GRANT, sampled each edge, release condition = !en OR !req[sel] OR hold_cnt==MAX_HOLD-1.
  - On release: state=IDLE, valid=0, grant=0, hold_cnt=0, ptr=(sel+1) mod 16.
  - Otherwise: hold_cnt increments.
- Requests from other requesters never pre-empt an active grant.
- Every release produces exactly one IDLE bubble cycle before the next grant. This also applies when the same requester wins again.
- last = valid & (hold_cnt==MAX_HOLD-1).
- Wrap-around: after sel=15 is released, ptr becomes 0.
- If only one requester is active, it wins again after the bubble.
- out is 0 whenever valid=0, independent of in.

## Timing
- Grant latency: a req first high before edge k (state IDLE, en=1) gives valid=1 after edge k, i.e. 1 cycle.
- Release latency: req[sel] low before edge k gives valid=0 after edge k. Holder-drop and en-drop behave the same way.
- A timeout grant lasts exactly MAX_HOLD cycles with valid=1, then 1 cycle with valid=0.
- Maximum wait for any continuously requesting input: 15×(MAX_HOLD+1) cycles after its first eligible IDLE cycle.
- sel, grant, valid and last change only at clk edges. out follows in combinationally while valid=1.
- If req[sel] drop and timeout occur at the same edge, it is a single release; ptr advances once.
- Reset mid-grant: all outputs are cleared at that edge. The first grant after reset searches from ptr=0.

## Test plan
- Reset: rst=1 for 3 cycles with req=0xFFFF, en=1 -> sel=0, grant=0, valid=0, last=0, out=0 throughout.
- Single holder: req=0x0020 for 3 cycles, then 0; in[5]=1 -> after the 1st edge sel=5, grant=0x0020, valid=1, out=1. valid=0 one edge after req drops. A following req=0x0021 then grants 0 (next set bit upward from ptr=6, wrapping).
- Timeout: req=0x0004 held, MAX_HOLD=8 -> valid=1 for exactly 8 cycles with last=1 on the 8th, 1 bubble, then sel=2 granted again.
- Round-robin wrap: req=0x8001 held -> winners 0, 15, 0, 15 in order, each 8 cycles, each followed by a 1-cycle bubble.
- Enable: en=0 with req=0x00FF -> no grant. Deasserting en at hold_cnt=3 of a grant -> valid=0 next edge, ptr=sel+1.
- Reset mid-grant: sel=9 at hold_cnt=4, rst pulsed for 1 cycle -> all outputs 0. With req=0x0030 afterwards -> sel=4 granted.
